hamming_scrubber: RTL
=====================

HAMMING_SCRUBBER -- requirements
Module: hamming_scrubber

Interface
REQ-001 The block SHALL have these parameters:
- n: default 15; codeword width.
- k: default 11; data width.
- DEPTH: default 256; memory words; AW = $clog2(DEPTH).
- INTERVAL: default 1024, minimum 1; idle cycles between scrub steps.

REQ-002 The block SHALL have these ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- enable_i  in  1  scrubbing enabled.
- clear_count_i  in  1  synchronous clear of sec_count_o.
- mem_busy_i  in  1  functional port owns memory this cycle; scrubber SHALL NOT access.
- mem_re_o  out  1  read strobe.
- mem_we_o  out  1  write strobe.
- mem_addr_o  out  AW  address.
- mem_wdata_o  out  n  corrected codeword.
- mem_rdata_i  in  n  read data, valid exactly 1 cycle after mem_re_o.
- sec_count_o  out  16  saturating count of corrected words.
- pass_done_o  out  1  1-cycle pulse when address wraps DEPTH-1 -> 0.
- busy_o  out  1  high in READ, CHECK, WRITE.

Function
REQ-003 The FSM SHALL have states IDLE, WAIT, READ, CHECK, WRITE, NEXT.
REQ-004 IDLE -> WAIT when enable_i=1; the interval timer loads INTERVAL.
REQ-005 WAIT SHALL last exactly INTERVAL cycles, then go to READ.
- If enable_i=0 in WAIT: go to IDLE.
REQ-006 READ:
- mem_busy_i=0: assert mem_re_o for 1 cycle at mem_addr_o, go to CHECK.
- mem_busy_i=1: hold READ, mem_re_o=0.
REQ-007 CHECK:
- mem_rdata_i goes into the correction sub-module.
- Register the corrected codeword and sec.
- sec=0 -> NEXT; sec=1 -> WRITE.
REQ-008 WRITE:
- mem_busy_i=0: assert mem_we_o for 1 cycle with the registered corrected codeword, increment sec_count_o, go to NEXT.
- mem_busy_i=1: abandon the write-back and return to READ at the same address, so user writes between read and write-back are never overwritten.
REQ-009 NEXT:
- Address increments modulo DEPTH.
- On DEPTH-1 -> 0, pulse pass_done_o in the same cycle.
- Go to WAIT if enable_i=1, else IDLE.
REQ-010 enable_i deassertion during READ/CHECK/WRITE SHALL NOT abort the in-flight word; it takes effect in NEXT.
REQ-011 Latency: mem_re_o to CHECK is 1 cycle; the earliest mem_we_o is 2 cycles after mem_re_o.
REQ-012 Uncorrectable/double errors are outside the SEC code. The scrubber writes back whatever the corrector outputs when sec=1 and takes no other action.
REQ-013 sec_count_o:
- Saturates at 16'hFFFF.
- clear_count_i sets it to 0 in the next cycle.
- Clear simultaneous with an increment: clear wins, result 0.
REQ-014 mem_re_o and mem_we_o SHALL never be high together, and never high while mem_busy_i=1.
REQ-015 All outputs SHALL be registered except mem_re_o/mem_we_o, which are decoded from state and mem_busy_i.

Reset
REQ-016 While rst=1 the block SHALL hold these values, applied asynchronously:
- state IDLE, address 0, timer 0, sec_count_o 0.
- mem_re_o, mem_we_o, pass_done_o, busy_o all 0.
- mem_wdata_o 0.
REQ-017 rst asserted mid-WRITE SHALL drop mem_we_o immediately; the word is rescrubbed on the next pass.

Structure
REQ-018 The shared package hamming_scrub_pkg SHALL hold the state enum typedef and the sec_count width constant (16).
REQ-019 The block SHALL instantiate exactly one h3_correct_n_k #(n,k) as its correction sub-module; no other correction logic.

Verification
Bench uses n=15, k=11, DEPTH=8, INTERVAL=4.
REQ-020 Scenario 1, clean memory: all words encoded, enable_i=1.
- Reads at addresses 0..7, spaced by 4 idle WAIT cycles.
- No mem_we_o; sec_count_o=0; pass_done_o pulses once per 8 words.
REQ-021 Scenario 2, single-bit errors: flip bit j of word j for j=0..7.
- Exactly 8 write-backs, each with the original codeword.
- sec_count_o=8 after one pass; 0 write-backs on the second pass.
REQ-022 Scenario 3, contention: mem_busy_i=1 for 10 cycles on entering READ.
- No strobe while busy; read issued on the first cycle busy drops.
REQ-023 Scenario 4, write-back abort: corrupted word at address 3; mem_busy_i=1 the cycle WRITE is entered.
- No mem_we_o; re-read of address 3; write-back follows; sec_count_o increments exactly once.
REQ-024 Scenario 5, counter edges:
- Preload sec_count_o to 16'hFFFE, run 3 corrections -> 16'hFFFF.
- clear_count_i on an increment cycle -> 0.
REQ-025 Scenario 6, reset/disable:
- rst pulsed mid-WRITE: all outputs 0 immediately; address restarts at 0.
- enable_i dropped in CHECK: the word completes, then IDLE.

Source files
------------

// File: rtl/hamming_scrub_pkg.sv
// rtl/hamming_scrub_pkg.sv - shared types and constants for the Hamming memory scrubber
package hamming_scrub_pkg;

    localparam int SEC_COUNT_W = 16;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        READ,
        CHECK,
        WRITE,
        NEXT
    } scrub_state_t;

endpackage

// File: rtl/h3_correct_n_k.sv
// rtl/h3_correct_n_k.sv - single-error correction for a positional Hamming(n,k) codeword
module h3_correct_n_k #(
    parameter int n = 15,
    parameter int k = 11
) (
    input  logic [n-1:0] codeword,
    output logic [n-1:0] corrected,
    output logic         sec
);

    localparam int R = n - k;

    logic [R-1:0] syndrome;

    // Bit at 1-based position p contributes p to the syndrome; a lone flip makes it point at itself.
    always_comb begin
        syndrome = '0;
        for (int p = 1; p <= n; p++) begin
            if (codeword[p-1]) begin
                syndrome = syndrome ^ R'(p);
            end
        end
    end

    always_comb begin
        corrected = codeword;
        for (int p = 1; p <= n; p++) begin
            corrected[p-1] = codeword[p-1] ^ (syndrome == R'(p));
        end
    end

    assign sec = |syndrome;

endmodule

// File: rtl/hamming_scrubber.sv
// rtl/hamming_scrubber.sv - background scrubber that reads, corrects and writes back SEC-protected words
module hamming_scrubber
    import hamming_scrub_pkg::*;
#(
    parameter int  n        = 15,
    parameter int  k        = 11,
    parameter int  DEPTH    = 256,
    parameter int  INTERVAL = 1024,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   enable_i,
    input  logic                   clear_count_i,
    input  logic                   mem_busy_i,
    output logic                   mem_re_o,
    output logic                   mem_we_o,
    output logic [AW-1:0]          mem_addr_o,
    output logic [n-1:0]           mem_wdata_o,
    input  logic [n-1:0]           mem_rdata_i,
    output logic [SEC_COUNT_W-1:0] sec_count_o,
    output logic                   pass_done_o,
    output logic                   busy_o
);

    localparam int TW = $clog2(INTERVAL + 1);

    scrub_state_t  state_q;
    scrub_state_t  state_d;
    logic [TW-1:0] timer_q;
    logic [n-1:0]  corrected;
    logic          sec;

    h3_correct_n_k #(.n(n), .k(k)) u_correct (
        .codeword  (mem_rdata_i),
        .corrected (corrected),
        .sec       (sec)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A busy port during WRITE sends us back to READ so a user write is never clobbered.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = WAIT;
            WAIT: begin
                if (!enable_i) begin
                    state_d = IDLE;
                end else if (timer_q == TW'(1)) begin
                    state_d = READ;
                end
            end
            READ:    if (!mem_busy_i) state_d = CHECK;
            CHECK:   state_d = sec ? WRITE : NEXT;
            WRITE:   state_d = mem_busy_i ? READ : NEXT;
            NEXT:    state_d = enable_i ? WAIT : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        mem_re_o = (state_q == READ)  && !mem_busy_i;
        mem_we_o = (state_q == WRITE) && !mem_busy_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            timer_q     <= '0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            pass_done_o <= 1'b0;
            busy_o      <= 1'b0;
        end else begin
            pass_done_o <= (state_d == NEXT) && (mem_addr_o == AW'(DEPTH - 1));
            busy_o      <= state_d inside {READ, CHECK, WRITE};
            if (state_d == WAIT && state_q != WAIT) begin
                timer_q <= TW'(INTERVAL);
            end else if (state_q == WAIT) begin
                timer_q <= timer_q - TW'(1);
            end
            if (state_q == CHECK) begin
                mem_wdata_o <= corrected;
            end
            if (state_q == NEXT) begin
                mem_addr_o <= (mem_addr_o == AW'(DEPTH - 1)) ? '0 : mem_addr_o + AW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sec_count_o <= '0;
        end else if (clear_count_i) begin
            sec_count_o <= '0;
        end else if (mem_we_o && sec_count_o != '1) begin
            sec_count_o <= sec_count_o + SEC_COUNT_W'(1);
        end
    end

endmodule
